// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared opcodes, state/class enums and control encodings for the
// RV32 multi-cycle control path.
package rv_ctrl_pkg;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [1:0] ALU_OP_ADD = 2'b00;
   localparam logic [1:0] ALU_OP_R   = 2'b10;
   localparam logic [1:0] ALU_OP_I   = 2'b11;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_IMEM    = 2'b10;
   localparam logic [1:0] CAUSE_DMEM    = 2'b11;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
   typedef enum logic [2:0] {NONE, R, IALU, LOAD, STORE} inst_class_t;
endpackage

// File: rtl/rv_opcode_decode.sv
// rv_opcode_decode: maps a 7-bit major opcode to its instruction class;
// anything outside R/I-ALU/LOAD/STORE is illegal.
module rv_opcode_decode
   import rv_ctrl_pkg::*;
(
   input  logic [6:0]  opcode_i,
   output inst_class_t class_o,
   output logic        legal_o
);
   always_comb begin
      class_o = opcode_i == OP_R     ? R     :
                opcode_i == OP_IALU  ? IALU  :
                opcode_i == OP_LOAD  ? LOAD  :
                opcode_i == OP_STORE ? STORE : NONE;
   end

   assign legal_o = class_o != NONE;
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// timeouts, illegal-opcode trap and a retired-instruction counter.
module rv_multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      inst,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic             rf_we,
   output logic             alu_src_imm,
   output logic             imm_sel,
   output logic [1:0]       alu_op,
   output logic             wb_sel,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] retired
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);

   state_t           state_q, state_d;
   inst_class_t      class_q, class_d, dec_class;
   logic             dec_legal;
   logic [WW-1:0]    wait_q, wait_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             wait_max;
   logic             alu_phase;

   rv_opcode_decode u_dec (
      .opcode_i(inst[6:0]),
      .class_o (dec_class),
      .legal_o (dec_legal)
   );

   // A ready seen while the count sits at MEM_TIMEOUT still wins over the trap.
   assign wait_max = wait_q == WW'(MEM_TIMEOUT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         class_q   <= NONE;
         wait_q    <= '0;
         cause_q   <= CAUSE_NONE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         wait_q    <= wait_d;
         cause_q   <= cause_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      cause_d   = cause_q;
      wait_d    = '0;
      retired_d = retired_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ready) state_d = S_DECODE;
            else if (wait_max) begin
               state_d = S_TRAP;
               cause_d = CAUSE_IMEM;
            end else wait_d = wait_q + 1'b1;
         end
         S_DECODE: begin
            class_d = dec_class;
            state_d = dec_legal ? S_EXEC : S_TRAP;
            cause_d = dec_legal ? cause_q : CAUSE_ILLEGAL;
         end
         S_EXEC: state_d = (class_q == LOAD || class_q == STORE) ? S_MEM : S_WB;
         S_MEM: begin
            if (dmem_ready) begin
               state_d   = class_q == STORE ? S_FETCH : S_WB;
               retired_d = class_q == STORE ? retired_q + 1'b1 : retired_q;
            end else if (wait_max) begin
               state_d = S_TRAP;
               cause_d = CAUSE_DMEM;
            end else wait_d = wait_q + 1'b1;
         end
         S_WB: begin
            state_d   = S_FETCH;
            retired_d = retired_q + 1'b1;
         end
         default: state_d = S_TRAP;
      endcase
   end

   // rst_n gates every request/enable so a reset mid-access drops them at once.
   always_comb begin
      imem_req    = rst_n && state_q == S_FETCH;
      ir_we       = imem_req && imem_ready;
      dmem_req    = rst_n && state_q == S_MEM;
      dmem_we     = dmem_req && class_q == STORE;
      pc_we       = rst_n && (state_q == S_WB || (dmem_we && dmem_ready));
      rf_we       = rst_n && state_q == S_WB;
      wb_sel      = rf_we && class_q == LOAD;
      alu_phase   = rst_n && (state_q == S_EXEC || state_q == S_MEM);
      alu_src_imm = alu_phase && class_q != R;
      imm_sel     = alu_phase && class_q == STORE;
      alu_op      = !alu_phase       ? ALU_OP_ADD :
                    class_q == R     ? ALU_OP_R   :
                    class_q == IALU  ? ALU_OP_I   : ALU_OP_ADD;
      trap        = state_q == S_TRAP;
      trap_cause  = cause_q;
      retired     = retired_q;
   end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: directed cycle-by-cycle checks of the control outputs
// with MEM_TIMEOUT=4 and a 2-bit retired counter so wrap-around is reachable.
module tb_rv_multicycle_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst;
   logic        imem_ready, dmem_ready;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
   logic        alu_src_imm, imm_sel, wb_sel, trap;
   logic [1:0]  alu_op, trap_cause;
   logic [1:0]  retired;
   logic [13:0] ctl;
   int          errors = 0;
   int          checks = 0;

   // Field order: imem_req ir_we dmem_req dmem_we pc_we rf_we src imm_sel alu_op wb_sel trap cause
   localparam logic [13:0] K_IDLE   = 14'b0_0_0_0_0_0_0_0_00_0_0_00;
   localparam logic [13:0] K_FETCH  = 14'b1_0_0_0_0_0_0_0_00_0_0_00;
   localparam logic [13:0] K_FETCHR = 14'b1_1_0_0_0_0_0_0_00_0_0_00;
   localparam logic [13:0] K_EXEC_R = 14'b0_0_0_0_0_0_0_0_10_0_0_00;
   localparam logic [13:0] K_EXEC_I = 14'b0_0_0_0_0_0_1_0_11_0_0_00;
   localparam logic [13:0] K_EXEC_L = 14'b0_0_0_0_0_0_1_0_00_0_0_00;
   localparam logic [13:0] K_EXEC_S = 14'b0_0_0_0_0_0_1_1_00_0_0_00;
   localparam logic [13:0] K_MEM_L  = 14'b0_0_1_0_0_0_1_0_00_0_0_00;
   localparam logic [13:0] K_MEM_S  = 14'b0_0_1_1_0_0_1_1_00_0_0_00;
   localparam logic [13:0] K_MEM_SR = 14'b0_0_1_1_1_0_1_1_00_0_0_00;
   localparam logic [13:0] K_WB_ALU = 14'b0_0_0_0_1_1_0_0_00_0_0_00;
   localparam logic [13:0] K_WB_LD  = 14'b0_0_0_0_1_1_0_0_00_1_0_00;
   localparam logic [13:0] K_TRAP_I = 14'b0_0_0_0_0_0_0_0_00_0_1_01;
   localparam logic [13:0] K_TRAP_F = 14'b0_0_0_0_0_0_0_0_00_0_1_10;

   assign ctl = {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, alu_src_imm,
                 imm_sel, alu_op, wb_sel, trap, trap_cause};

   always #5 clk = ~clk;

   rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst       (inst),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .rf_we      (rf_we),
      .alu_src_imm(alu_src_imm),
      .imm_sel    (imm_sel),
      .alu_op     (alu_op),
      .wb_sel     (wb_sel),
      .trap       (trap),
      .trap_cause (trap_cause),
      .retired    (retired)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, drive the readies just after the edge, settle before sampling.
   task automatic next(input logic ir, input logic dr);
      @(posedge clk);
      #1 imem_ready = ir;
      dmem_ready = dr;
      #3;
   endtask

   initial begin
      rst_n = 1'b0;
      inst = 32'h0;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      #3 chk("reset_ctl", ctl, K_IDLE);
      chk("reset_retired", retired, 0);
      #9 rst_n = 1'b1;
      inst = 32'h00208033;
      #2 chk("r_fetch", ctl, K_FETCHR);
      next(0, 0); chk("r_decode", ctl, K_IDLE);
      next(0, 0); chk("r_exec", ctl, K_EXEC_R);
      next(0, 0); chk("r_wb", ctl, K_WB_ALU);
      chk("r_ret_before", retired, 0);
      next(1, 0); chk("ld_fetch", ctl, K_FETCHR);
      chk("r_ret_after", retired, 1);
      inst = 32'h00402083;
      next(0, 0); chk("ld_decode", ctl, K_IDLE);
      next(0, 0); chk("ld_exec", ctl, K_EXEC_L);
      next(0, 0); chk("ld_mem1", ctl, K_MEM_L);
      next(0, 0); chk("ld_mem2", ctl, K_MEM_L);
      next(0, 0); chk("ld_mem3", ctl, K_MEM_L);
      next(0, 1); chk("ld_mem4", ctl, K_MEM_L);
      next(0, 0); chk("ld_wb", ctl, K_WB_LD);
      next(1, 0); chk("st_fetch", ctl, K_FETCHR);
      chk("ld_ret", retired, 2);
      inst = 32'h00112223;
      next(0, 0); chk("st_decode", ctl, K_IDLE);
      next(0, 0); chk("st_exec", ctl, K_EXEC_S);
      next(0, 0); chk("st_mem_wait", ctl, K_MEM_S);
      next(0, 1); chk("st_mem_rdy", ctl, K_MEM_SR);
      next(1, 0); chk("r2_fetch", ctl, K_FETCHR);
      chk("st_ret", retired, 3);
      inst = 32'h00208033;
      next(0, 0); chk("r2_decode", ctl, K_IDLE);
      next(0, 0); chk("r2_exec", ctl, K_EXEC_R);
      next(0, 0); chk("r2_wb", ctl, K_WB_ALU);
      // Ready arrives when the wait count has just reached MEM_TIMEOUT: fetch proceeds.
      next(0, 0); chk("ret_wrap", retired, 0);
      chk("late_w0", ctl, K_FETCH);
      next(0, 0); chk("late_w1", ctl, K_FETCH);
      next(0, 0); chk("late_w2", ctl, K_FETCH);
      next(0, 0); chk("late_w3", ctl, K_FETCH);
      next(1, 0); chk("late_w4_rdy", ctl, K_FETCHR);
      inst = 32'h00500093;
      next(0, 0); chk("i_decode", ctl, K_IDLE);
      next(0, 0); chk("i_exec", ctl, K_EXEC_I);
      next(0, 0); chk("i_wb", ctl, K_WB_ALU);
      next(1, 0); chk("ill_fetch", ctl, K_FETCHR);
      chk("i_ret", retired, 1);
      inst = 32'h0000007F;
      next(1, 1); chk("ill_decode", ctl, K_IDLE);
      for (int i = 0; i < 21; i++) begin
         next(1, 1);
         chk("ill_trap", ctl, K_TRAP_I);
      end
      chk("ill_ret_frozen", retired, 1);
      rst_n = 1'b0;
      #1 chk("trap_reset", ctl, K_IDLE);
      chk("trap_reset_ret", retired, 0);
      #2 rst_n = 1'b1;
      imem_ready = 1'b0;
      #1 chk("to_w0", ctl, K_FETCH);
      next(0, 0); chk("to_w1", ctl, K_FETCH);
      next(0, 0); chk("to_w2", ctl, K_FETCH);
      next(0, 0); chk("to_w3", ctl, K_FETCH);
      next(0, 0); chk("to_w4", ctl, K_FETCH);
      next(0, 0); chk("to_trap", ctl, K_TRAP_F);
      next(1, 0); chk("to_sticky", ctl, K_TRAP_F);
      rst_n = 1'b0;
      #3 rst_n = 1'b1;
      imem_ready = 1'b1;
      inst = 32'h00402083;
      #1 chk("rm_fetch", ctl, K_FETCHR);
      next(0, 0); chk("rm_decode", ctl, K_IDLE);
      next(0, 0); chk("rm_exec", ctl, K_EXEC_L);
      next(0, 0); chk("rm_mem", ctl, K_MEM_L);
      rst_n = 1'b0;
      #1 chk("rm_reset_drop", ctl, K_IDLE);
      #2 rst_n = 1'b1;
      #1 chk("rm_release", ctl, K_FETCH);
      chk("rm_ret", retired, 0);
      next(0, 0); chk("rm_refetch", ctl, K_FETCH);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Control FSM that sequences the RISC-V R/I/S-type datapath (PC, IR, register file, immediate generator, ALU, data memory) as a multi-cycle machine.
- Handshakes with the instruction and data memories, latches the instruction class at decode, and drives every write-enable and mux select.
- Selects I- or S-format immediate for the immediate generator.
- Traps on illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before a bus-error trap (≥1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst  in  32  current IR contents; valid from the cycle after ir_we.
- imem_ready  in  1  instruction memory has data; sampled while imem_req=1.
- dmem_ready  in  1  data memory completed access; sampled while dmem_req=1.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data access is a store.
- ir_we  out  1  load IR from instruction memory.
- pc_we  out  1  PC <= PC+4.
- rf_we  out  1  register file write.
- alu_src_imm  out  1  ALU operand B = immediate (0 = rs2).
- imm_sel  out  1  immediate format: 0 = I (inst[31:20]), 1 = S ({inst[31:25],inst[11:7]}).
- alu_op  out  2  00 = add (address), 10 = R-type funct decode, 11 = I-type funct decode.
- wb_sel  out  1  write-back source: 0 = ALU, 1 = load data.
- trap  out  1  sticky: core halted.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. State and all outputs are asynchronously forced on rst_n=0.
- Reset values: state = FETCH, class = NONE, counters = 0, trap = 0, trap_cause = 00, retired = 0.
  - All request and enable outputs are 0 during reset.
  - imem_req rises in the first cycle after rst_n deasserts.
- Outputs are decoded combinationally from the state and the latched class register (Moore style). There is no combinational path from ready inputs to any enable except those listed below.
- FETCH:
  - imem_req = 1.
  - When imem_ready = 1 in the same cycle: ir_we = 1 and next state is DECODE. Zero-wait memory therefore costs one FETCH cycle.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: one cycle. Latch class from inst[6:0]:
  - 0110011 → R.
  - 0010011 → IALU.
  - 0000011 → LOAD.
  - 0100011 → STORE.
  - Anything else → trap_cause = 01, go to TRAP.
- EXEC: one cycle. Output settings by class:
  - R: alu_src_imm = 0, alu_op = 10.
  - IALU: alu_src_imm = 1, imm_sel = 0, alu_op = 11.
  - LOAD: alu_src_imm = 1, imm_sel = 0, alu_op = 00.
  - STORE: alu_src_imm = 1, imm_sel = 1, alu_op = 00.
  - Next state: R/IALU → WB; LOAD/STORE → MEM.
- MEM:
  - dmem_req = 1 and dmem_we = (class == STORE). ALU controls are held as in EXEC.
  - On dmem_ready: STORE asserts pc_we = 1 and retires, going to FETCH. LOAD goes to WB.
- WB:
  - rf_we = 1, pc_we = 1, and retired increments.
  - wb_sel = 1 for LOAD, 0 otherwise.
  - Next state is FETCH.
- Instruction latency with zero-wait memory:
  - R/I: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle the ready input is low.
  - If it reaches MEM_TIMEOUT while ready is still low, go to TRAP with cause 10 (FETCH) or 11 (MEM).
  - A ready arriving in the same cycle the count hits MEM_TIMEOUT wins: no trap.
- TRAP: absorbing. trap = 1; all enables and requests are 0; PC is not advanced. Only rst_n exits it.
- retired wraps modulo 2^CNT_W without a flag.
- Reset mid-request drops imem_req/dmem_req immediately (asynchronously). No partial rf_we or pc_we may be issued.
- Ready inputs are ignored outside their own request state.

Decomposition:
- Shared package rv_ctrl_pkg:
  - opcode localparams OP_R, OP_IALU, OP_LOAD, OP_STORE;
  - enum state_t;
  - enum inst_class_t {NONE, R, IALU, LOAD, STORE};
  - ALU_OP_* and CAUSE_* constants.
- Sub-module rv_opcode_decode: pure combinational inst[6:0] → inst_class_t plus a legal flag, reused later by a pipelined core.
- The FSM, wait counter and retired counter stay in the top module.

Test Plan:
- Zero-wait memories, R-type 0x00208033 → FETCH, DECODE, EXEC, WB over 4 cycles. rf_we = 1 only in cycle 4, where pc_we = 1 and retired 0 → 1.
- Load 0x00402083 with dmem_ready delayed 3 cycles → dmem_req held 4 cycles with dmem_we = 0, imm_sel = 0, alu_op = 00. The WB cycle has wb_sel = 1 and rf_we = 1; total 8 cycles.
- Store 0x00112223 → imm_sel = 1 in EXEC and MEM; dmem_we = 1; pc_we is high in the dmem_ready cycle; rf_we never asserts; retired increments.
- Opcode 0x0000007F → trap = 1, cause = 01 after DECODE. All outputs stay 0 for 20 further cycles with imem_ready held high.
- imem_ready held low with MEM_TIMEOUT = 4 → trap with cause 10 exactly at the 4th wait. A second run with ready arriving at count 4 → no trap and normal fetch.
- Assert rst_n = 0 mid-MEM with dmem_req = 1 → dmem_req drops the same cycle and state returns to FETCH. retired = 0 and trap = 0 after release, and the first imem_req appears the next cycle.
